vec_stream_tx: RTL and testbench
================================

VEC_STREAM_TX -- requirements
Module: vec_stream_tx

Interface
REQ-001 The module SHALL have parameter DATA_W, 64, width of one streamed data word.
REQ-002 The module SHALL have parameter ADDR_W, 8, SRAM word-address width.
REQ-003 The module SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port start  input  1  command strobe; sampled only in IDLE.
REQ-006 The module SHALL have port base_addr  input  ADDR_W  first SRAM address; sampled with start.
REQ-007 The module SHALL have port len  input  ADDR_W+1  word count, 0..2^ADDR_W; sampled with start.
REQ-008 The module SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The module SHALL have port mem_ren  output  1  SRAM read enable.
REQ-011 The module SHALL have port mem_addr  output  ADDR_W  SRAM read address, valid with mem_ren.
REQ-012 The module SHALL have port mem_rdata  input  DATA_W  SRAM read data, valid exactly 1 cycle after mem_ren.
REQ-013 The module SHALL have port vld_out  output  1  downstream valid.
REQ-014 The module SHALL have port rdy_in  input  1  downstream ready.
REQ-015 The module SHALL have port data_out  output  DATA_W  streamed word.
REQ-016 The module SHALL have port last_out  output  1  marks final word of the command.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM, FINISH; start in IDLE with len>0 -> STREAM; start in IDLE with len=0 -> FINISH; final handshake in STREAM -> FINISH; FINISH -> IDLE unconditionally.
REQ-018 done SHALL be high only in FINISH, so it pulses exactly 1 cycle after start (len=0) or 1 cycle after the final handshake.
REQ-019 start while busy SHALL be ignored, with no effect on counters or captured operands.
REQ-020 An internal 2-entry FIFO SHALL buffer returned read data; vld_out = FIFO non-empty; data_out = FIFO head.
REQ-021 A handshake SHALL occur when vld_out && rdy_in, popping the FIFO head in that cycle.
REQ-022 In STREAM, mem_ren SHALL assert iff issued < len and (fifo_count + inflight - pop) < 2, where inflight = mem_ren of the previous cycle and pop = current handshake.
REQ-023 mem_addr SHALL equal (base_addr + issued) mod 2^ADDR_W; issued SHALL increment on each mem_ren.
REQ-024 mem_rdata SHALL be written to the FIFO tail in the cycle after mem_ren; simultaneous write and pop SHALL both take effect.
REQ-025 The FIFO SHALL never overflow; any write into a full FIFO is a design error and SHALL be flagged by an assertion.
REQ-026 last_out SHALL be high iff vld_out and the head word is word index len-1.
REQ-027 While vld_out && !rdy_in, data_out and last_out SHALL hold stable, and vld_out SHALL not deassert.
REQ-028 With rdy_in held high, the first vld_out SHALL rise 3 cycles after the start-sampling edge, and one word SHALL transfer per cycle thereafter.
REQ-029 Words SHALL be emitted in address order with no duplication or loss under any rdy_in pattern.
REQ-030 mem_ren SHALL be low in IDLE and FINISH.

Reset
REQ-031 While rst is high at a posedge, the block SHALL enter IDLE; busy, done, mem_ren, vld_out, and last_out SHALL be 0; the FIFO and counters SHALL clear.
REQ-032 Reset mid-command SHALL abort the command; read data returning in the cycle after reset SHALL be discarded, and no done SHALL be generated.
REQ-033 data_out and mem_addr SHALL read 0 after reset.

Verification
REQ-034 base=0x10, len=4, rdy_in=1 -> mem_ren at cycles 1-4 with addr 0x10..0x13; vld_out at cycles 3-6; last_out at cycle 6; done at cycle 7.
REQ-035 len=0 -> done=1 at cycle 1, busy=1 at cycle 1 only, no mem_ren, no vld_out.
REQ-036 base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01, with data order preserved.
REQ-037 len=8, random rdy_in at 30% duty -> 8 words delivered in order, data stable while stalled, FIFO never overflows, done exactly once.
REQ-038 rdy_in=0 for 10 cycles after start, len=5 -> exactly 2 reads issued and stalled; resuming rdy_in delivers all 5 words.
REQ-039 rst asserted at mid-stream word 3 of 6 -> next cycle all outputs 0; new start then streams correctly from its own base.

Source files
------------

// File: rtl/vec_stream_tx_if.sv
// Bundle of command, SRAM read port and downstream stream signals for vec_stream_tx.
// The master modport is the transmitter; the slave modport is its environment.
interface vec_stream_tx_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              vld_out;
  logic              rdy_in;
  logic [DATA_W-1:0] data_out;
  logic              last_out;

  modport master (
    input  start, base_addr, len, mem_rdata, rdy_in,
    output busy, done, mem_ren, mem_addr, vld_out, data_out, last_out
  );

  modport slave (
    output start, base_addr, len, mem_rdata, rdy_in,
    input  busy, done, mem_ren, mem_addr, vld_out, data_out, last_out
  );
endinterface

// File: rtl/vec_stream_tx.sv
// Streams a contiguous block of SRAM words to a valid/ready sink.
// Reads are throttled so that data still in flight from the one-cycle SRAM
// always has a slot in the 2-entry output FIFO, which keeps full throughput
// with a ready sink while never overflowing under backpressure.
module vec_stream_tx #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  vec_stream_tx_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   popped;
  logic [ADDR_W:0]   last_idx;
  logic              inflight;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              pop;
  logic              ren;
  logic              final_hs;
  logic [2:0]        occupancy;

  // Handshake, read throttling and end-of-command detection.
  always_comb begin
    pop       = 1'b0;
    occupancy = 3'd0;
    ren       = 1'b0;
    final_hs  = 1'b0;
    last_idx  = len_q - {{ADDR_W{1'b0}}, 1'b1};
    pop       = (count != 2'd0) && bus.rdy_in;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    ren       = (state == STREAM) && (issued < len_q) && (occupancy < 3'd2);
    final_hs  = (state == STREAM) && pop && (popped == last_idx);
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == FINISH);
  assign bus.mem_ren  = ren;
  assign bus.mem_addr = base_q + issued[ADDR_W-1:0];
  assign bus.vld_out  = (count != 2'd0);
  assign bus.data_out = fifo_mem[rd_ptr];
  assign bus.last_out = (count != 2'd0) && (popped == last_idx);

  // Command FSM: captures operands on an idle start and tracks issued/delivered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      popped <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            base_q <= bus.base_addr;
            len_q  <= bus.len;
            issued <= '0;
            popped <= '0;
            state  <= (bus.len == '0) ? FINISH : STREAM;
          end
        end
        STREAM: begin
          if (ren) issued <= issued + 1'b1;
          if (pop) popped <= popped + 1'b1;
          if (final_hs) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output FIFO: read data lands one cycle after its request; write and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= ren;
      if (inflight) begin
        fifo_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Guard against a returning word finding no free FIFO slot.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight && (count == 2'd2) && !pop))
        else $error("vec_stream_tx: write into full FIFO");
    end
  end

endmodule

// File: tb/tb_vec_stream_tx.sv
// Self-checking bench for vec_stream_tx: an SRAM model, a queue-based
// reference of the expected word stream, and directed command scenarios.
module tb_vec_stream_tx;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   rdy_mode = 0;

  vec_stream_tx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vec_stream_tx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Distinct, address-dependent content for every SRAM word.
  function automatic logic [63:0] word_of(logic [7:0] a);
    return {8'hA5, a, 16'hBEEF ^ {a, ~a}, 24'(a) * 24'd7, a ^ 8'h5A};
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= word_of(bus.mem_addr);
  end

  // Downstream ready pattern: 0 = always ready, 1 = ~30% ready, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       bus.rdy_in = ($urandom_range(0, 99) < 30);
      2:       bus.rdy_in = 1'b0;
      default: bus.rdy_in = 1'b1;
    endcase
  end

  // Reference model state: words and addresses still owed for the current command.
  logic [63:0] exp_data [$];
  logic [7:0]  exp_addr [$];
  bit          active = 0;
  bit          fin = 0;
  int          outstanding = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_data;
  logic        prev_last;
  int          ren_count = 0;
  int          done_count = 0;
  int          hs_count = 0;

  // Per-cycle comparison of every DUT output against the reference model.
  always @(negedge clk) begin
    bit idle_now;
    bit hs;
    bit new_fin;
    if (rst) begin
      exp_data.delete();
      exp_addr.delete();
      active      = 0;
      fin         = 0;
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      idle_now = !active && !fin;
      new_fin  = 0;
      check_output("busy", bus.busy, active || fin);
      check_output("done", bus.done, fin);
      if (bus.done) done_count++;
      if (prev_stall) begin
        check_output("stall_vld", bus.vld_out, 1'b1);
        check_output("stall_data", bus.data_out, prev_data);
        check_output("stall_last", bus.last_out, prev_last);
      end
      if (bus.vld_out) begin
        if (exp_data.size() == 0) check_output("spurious_vld", bus.vld_out, 1'b0);
        else begin
          check_output("data_out", bus.data_out, exp_data[0]);
          check_output("last_out", bus.last_out, exp_data.size() == 1);
        end
      end else begin
        check_output("last_without_vld", bus.last_out, 1'b0);
      end
      if (!active) check_output("ren_when_not_streaming", bus.mem_ren, 1'b0);
      if (bus.mem_ren) begin
        ren_count++;
        if (exp_addr.size() == 0) check_output("extra_ren", bus.mem_ren, 1'b0);
        else check_output("mem_addr", bus.mem_addr, exp_addr.pop_front());
      end
      hs = bus.vld_out && bus.rdy_in;
      outstanding += int'(bus.mem_ren) - int'(hs);
      check_output("occupancy_over_2", outstanding > 2, 1'b0);
      if (hs && exp_data.size() > 0) begin
        void'(exp_data.pop_front());
        hs_count++;
        if (exp_data.size() == 0 && active) begin
          active  = 0;
          new_fin = 1;
        end
      end
      prev_stall = bus.vld_out && !bus.rdy_in;
      prev_data  = bus.data_out;
      prev_last  = bus.last_out;
      if (idle_now && bus.start) begin
        if (bus.len == '0) new_fin = 1;
        else begin
          active = 1;
          for (int i = 0; i < int'(bus.len); i++) begin
            exp_data.push_back(word_of(bus.base_addr + 8'(i)));
            exp_addr.push_back(bus.base_addr + 8'(i));
          end
        end
      end
      fin = new_fin;
    end
  end

  // Issue one command; start is high for exactly one sampling edge.
  task automatic apply_stimulus(logic [7:0] base, logic [8:0] len);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = len;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.vld_out) && n < 2000);
    check_output(name, bus.busy, 1'b0);
  endtask

  task automatic check_all_zero(string tag);
    check_output({tag, "_busy"}, bus.busy, 1'b0);
    check_output({tag, "_done"}, bus.done, 1'b0);
    check_output({tag, "_ren"}, bus.mem_ren, 1'b0);
    check_output({tag, "_vld"}, bus.vld_out, 1'b0);
    check_output({tag, "_last"}, bus.last_out, 1'b0);
    check_output({tag, "_data"}, bus.data_out, 64'h0);
    check_output({tag, "_addr"}, bus.mem_addr, 8'h00);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    logic [7:0] seen [$];
    logic [7:0] wrap_exp [4];
    int d0, r0, h0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.rdy_in    = 1'b1;
    bus.mem_rdata = '0;
    wrap_exp      = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // base 0x10, len 4, always ready: literal cycle-by-cycle timeline.
    $display("[TB] basic timeline");
    d0 = done_count;
    apply_stimulus(8'h10, 9'd4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_output($sformatf("t%0d_ren", c), bus.mem_ren, (c >= 1 && c <= 4));
      if (c <= 4) check_output($sformatf("t%0d_addr", c), bus.mem_addr, 8'h10 + 8'(c - 1));
      check_output($sformatf("t%0d_vld", c), bus.vld_out, (c >= 3 && c <= 6));
      if (c >= 3 && c <= 6)
        check_output($sformatf("t%0d_data", c), bus.data_out, word_of(8'h10 + 8'(c - 3)));
      check_output($sformatf("t%0d_last", c), bus.last_out, c == 6);
      check_output($sformatf("t%0d_done", c), bus.done, c == 7);
    end
    wait_idle("basic_idle");
    check_output("basic_done_count", done_count - d0, 1);

    // Zero-length command.
    $display("[TB] zero length");
    d0 = done_count; r0 = ren_count;
    apply_stimulus(8'h33, 9'd0);
    @(negedge clk);
    check_output("len0_busy_c1", bus.busy, 1'b1);
    check_output("len0_done_c1", bus.done, 1'b1);
    check_output("len0_vld_c1", bus.vld_out, 1'b0);
    @(negedge clk);
    check_output("len0_busy_c2", bus.busy, 1'b0);
    check_output("len0_done_c2", bus.done, 1'b0);
    check_output("len0_done_count", done_count - d0, 1);
    check_output("len0_ren_count", ren_count - r0, 0);

    // Address wrap at the top of the SRAM.
    $display("[TB] address wrap");
    h0 = hs_count;
    apply_stimulus(8'hFE, 9'd4);
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_ren) seen.push_back(bus.mem_addr);
    end
    check_output("wrap_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("wrap_addr%0d", i), (i < seen.size()) ? seen[i] : 8'hxx, wrap_exp[i]);
    wait_idle("wrap_idle");
    check_output("wrap_words", hs_count - h0, 4);

    // Random backpressure at ~30% ready.
    $display("[TB] random backpressure");
    rdy_mode = 1;
    d0 = done_count; h0 = hs_count;
    apply_stimulus(8'h80, 9'd8);
    wait_idle("random_idle");
    check_output("random_words", hs_count - h0, 8);
    check_output("random_done_count", done_count - d0, 1);
    rdy_mode = 0;

    // Sink stalled for 10 cycles: only two reads may be outstanding.
    $display("[TB] initial stall");
    rdy_mode = 2;
    r0 = ren_count; h0 = hs_count;
    apply_stimulus(8'h20, 9'd5);
    repeat (10) @(negedge clk);
    check_output("stall_reads", ren_count - r0, 2);
    check_output("stall_head_vld", bus.vld_out, 1'b1);
    check_output("stall_head_data", bus.data_out, word_of(8'h20));
    rdy_mode = 0;
    wait_idle("stall_idle");
    check_output("stall_words", hs_count - h0, 5);

    // Reset in the middle of a 6-word command, then a fresh command.
    $display("[TB] mid-stream reset");
    d0 = done_count;
    apply_stimulus(8'h50, 9'd6);
    repeat (5) @(negedge clk);
    check_output("pre_reset_head", bus.data_out, word_of(8'h52));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check_output("abort_no_vld", bus.vld_out, 1'b0);
    end
    check_output("abort_no_done", done_count - d0, 0);
    h0 = hs_count;
    apply_stimulus(8'h40, 9'd3);
    wait_idle("restart_idle");
    check_output("restart_words", hs_count - h0, 3);
    check_output("restart_done_count", done_count - d0, 1);

    check_output("leftover_words", exp_data.size(), 0);
    check_output("leftover_addrs", exp_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
